// File: rtl/wr_pkt_arbiter_mc_if.sv
// Bundled requester-side and FIFO-side handshake signals of the write-back packetizer.
// The master modport is the packetizer; the slave modport is the requesters plus write FIFO.
interface wr_pkt_arbiter_mc_if #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TX_WIDTH    = 16,
  parameter int CODE_WIDTH  = 4,
  parameter int SCHED_WIDTH = 8
);
  logic [NUM_CH-1:0]             ch_req;
  logic [NUM_CH*CODE_WIDTH-1:0]  ch_code;
  logic [NUM_CH*SCHED_WIDTH-1:0] ch_schedule;
  logic [NUM_CH*TX_WIDTH-1:0]    ch_size;
  logic [NUM_CH-1:0]             ch_grant;
  logic [NUM_CH-1:0]             ch_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]  ch_data;
  logic [NUM_CH-1:0]             ch_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_sop;
  logic                          out_last;
  logic                          out_ready;

  modport master (
    input  ch_req, ch_code, ch_schedule, ch_size, ch_valid, ch_data, out_ready,
    output ch_grant, ch_ready, out_valid, out_data, out_sop, out_last
  );

  modport slave (
    output ch_req, ch_code, ch_schedule, ch_size, ch_valid, ch_data, out_ready,
    input  ch_grant, ch_ready, out_valid, out_data, out_sop, out_last
  );
endinterface

// File: rtl/wr_pkt_arbiter_mc.sv
// Round-robin multi-channel write packetizer: one header word then size payload words,
// pushed through a 2-entry registered skid buffer toward the async write FIFO.
module wr_pkt_arbiter_mc #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TX_WIDTH    = 16,
  parameter int CODE_WIDTH  = 4,
  parameter int SCHED_WIDTH = 8
) (
  input  logic                  clk_chip,
  input  logic                  reset_n_chip,
  input  logic                  flush,
  wr_pkt_arbiter_mc_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] done_ch
);
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HDR_CH_LSB = DATA_WIDTH - CODE_WIDTH - SCHED_WIDTH - CH_W;

  typedef enum logic [2:0] {IDLE, ARB, HDR, PAY, DRAIN} state_e;

  typedef struct packed {
    logic                  sop;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic [CH_W-1:0]        gnt_q, gnt_d;
  logic [CODE_WIDTH-1:0]  code_q, code_d;
  logic [SCHED_WIDTH-1:0] sched_q, sched_d;
  logic [TX_WIDTH-1:0]    size_q, size_d;
  logic [TX_WIDTH-1:0]    cnt_q, cnt_d;
  logic [TX_WIDTH-1:0]    cntInc;
  word_t                  head_q, head_d, tail_q, tail_d, pushWord;
  logic [1:0]             skidCnt_q, skidCnt_d;
  logic                   push, pop, skidFull, skidEmpty;
  logic                   readyEn, gntActive, gntValid;
  logic [DATA_WIDTH-1:0]  gntData, header;
  logic [CH_W-1:0]        arbIdx;
  logic                   arbFound;
  int                     arbDist, arbBest;
  logic [CODE_WIDTH-1:0]  reqCode;
  logic [SCHED_WIDTH-1:0] reqSched;
  logic [TX_WIDTH-1:0]    reqSize;

  assign skidEmpty = (skidCnt_q == 2'd0);
  assign skidFull  = (skidCnt_q == 2'd2);
  assign pop       = bus.out_valid && bus.out_ready;
  assign cntInc    = cnt_q + TX_WIDTH'(1);
  assign gntActive = (state_q == HDR) || (state_q == PAY) || (state_q == DRAIN);

  // Requester closest at-or-after the pointer wins; distance wraps modulo NUM_CH.
  always_comb begin
    arbIdx   = '0;
    arbFound = 1'b0;
    arbBest  = NUM_CH;
    arbDist  = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      arbDist = (j + NUM_CH - int'(ptr_q)) % NUM_CH;
      if (bus.ch_req[j] && (arbDist < arbBest)) begin
        arbBest  = arbDist;
        arbIdx   = CH_W'(j);
        arbFound = 1'b1;
      end
    end
  end

  always_comb begin
    reqCode  = '0;
    reqSched = '0;
    reqSize  = '0;
    gntValid = 1'b0;
    gntData  = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (arbIdx == CH_W'(j)) begin
        reqCode  = bus.ch_code[j*CODE_WIDTH +: CODE_WIDTH];
        reqSched = bus.ch_schedule[j*SCHED_WIDTH +: SCHED_WIDTH];
        reqSize  = bus.ch_size[j*TX_WIDTH +: TX_WIDTH];
      end
      if (gnt_q == CH_W'(j)) begin
        gntValid = bus.ch_valid[j];
        gntData  = bus.ch_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    header = '0;
    header[DATA_WIDTH-1 -: CODE_WIDTH]             = code_q;
    header[DATA_WIDTH-CODE_WIDTH-1 -: SCHED_WIDTH] = sched_q;
    header[HDR_CH_LSB +: CH_W]                     = gnt_q;
    header[TX_WIDTH-1:0]                           = size_q;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    code_d   = code_q;
    sched_d  = sched_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pushWord = '0;
    readyEn  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.ch_req) state_d = ARB;
      end
      ARB: begin
        if (arbFound) begin
          gnt_d   = arbIdx;
          code_d  = reqCode;
          sched_d = reqSched;
          size_d  = reqSize;
          cnt_d   = '0;
          state_d = HDR;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (!skidFull) begin
          push     = 1'b1;
          pushWord = '{sop: 1'b1, last: (size_q == '0), data: header};
          state_d  = (size_q == '0) ? DRAIN : PAY;
        end
      end
      PAY: begin
        readyEn = !skidFull && (cnt_q < size_q);
        if (readyEn && gntValid) begin
          push     = 1'b1;
          pushWord = '{sop: 1'b0, last: (cntInc == size_q), data: gntData};
          cnt_d    = cntInc;
          if (cntInc == size_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (skidEmpty) begin
          done    = 1'b1;
          ptr_d   = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + CH_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything except reset and leaves the pointer where it was.
    if (flush) begin
      state_d = IDLE;
      ptr_d   = ptr_q;
      push    = 1'b0;
      readyEn = 1'b0;
      done    = 1'b0;
    end
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    skidCnt_d = skidCnt_q;
    case (skidCnt_q)
      2'd0: begin
        if (push) begin
          head_d    = pushWord;
          skidCnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = pushWord;
        end else if (push) begin
          tail_d    = pushWord;
          skidCnt_d = 2'd2;
        end else if (pop) begin
          skidCnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = pushWord;
          else      skidCnt_d = 2'd1;
        end
      end
    endcase
    if (flush) skidCnt_d = 2'd0;
  end

  always_ff @(posedge clk_chip) begin
    if (!reset_n_chip) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      code_q    <= '0;
      sched_q   <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      skidCnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      code_q    <= code_d;
      sched_q   <= sched_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      skidCnt_q <= skidCnt_d;
    end
  end

  always_comb begin
    bus.ch_grant = '0;
    bus.ch_ready = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      bus.ch_grant[j] = gntActive && (gnt_q == CH_W'(j));
      bus.ch_ready[j] = readyEn && (gnt_q == CH_W'(j));
    end
  end

  assign bus.out_valid = !skidEmpty;
  assign bus.out_data  = head_q.data;
  assign bus.out_sop   = head_q.sop && !skidEmpty;
  assign bus.out_last  = head_q.last && !skidEmpty;
  assign busy          = (state_q != IDLE) || !skidEmpty;
  assign done_ch       = gnt_q;
endmodule

// File: tb/tb_wr_pkt_arbiter_mc.sv
// Directed bench for wr_pkt_arbiter_mc: per-channel sources, FIFO-side capture queue and
// hand-built expected packets compared word by word.
module tb_wr_pkt_arbiter_mc;
  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int TXW    = 16;
  localparam int CW     = 4;
  localparam int SW     = 8;

  logic       clk_chip = 1'b0;
  logic       reset_n_chip;
  logic       flush;
  logic       busy;
  logic       done;
  logic [1:0] done_ch;

  logic [CW-1:0]  codeArr[NUM_CH];
  logic [SW-1:0]  schedArr[NUM_CH];
  logic [TXW-1:0] sizeArr[NUM_CH];
  logic [DW-1:0]  dataArr[NUM_CH];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [33:0] outQ[$];
  int          doneQ[$];
  int          srcSeq[NUM_CH];
  int          expSeq[NUM_CH];
  logic [NUM_CH-1:0] pendAcc;
  logic        toggleMode = 1'b0;
  int          togCnt = 0;
  logic        stallPrev = 1'b0;
  logic [33:0] heldWord = '0;
  int          lastAccCyc = 0;
  int          doneCyc = 0;
  int          startSeq;
  int          n;

  always #5 clk_chip = ~clk_chip;

  wr_pkt_arbiter_mc_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TX_WIDTH(TXW),
                         .CODE_WIDTH(CW), .SCHED_WIDTH(SW)) bus ();

  for (genvar g = 0; g < NUM_CH; g++) begin : gPack
    assign bus.ch_code[g*CW +: CW]      = codeArr[g];
    assign bus.ch_schedule[g*SW +: SW]  = schedArr[g];
    assign bus.ch_size[g*TXW +: TXW]    = sizeArr[g];
    assign bus.ch_data[g*DW +: DW]      = dataArr[g];
  end

  wr_pkt_arbiter_mc #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TX_WIDTH(TXW),
                      .CODE_WIDTH(CW), .SCHED_WIDTH(SW)) dut (
    .clk_chip     (clk_chip),
    .reset_n_chip (reset_n_chip),
    .flush        (flush),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .done_ch      (done_ch)
  );

  function automatic logic [31:0] mkWord(int ch, int seq);
    return 32'hD000_0000 | (32'(ch) << 16) | (32'(seq) & 32'h0000_FFFF);
  endfunction

  function automatic logic [31:0] hdrWord(logic [3:0] c, logic [7:0] s, int ch, logic [15:0] sz);
    logic [1:0] c2;
    c2 = 2'(ch);
    return {c, s, c2, 2'b00, sz};
  endfunction

  task automatic checkOutput(string tag, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(int ch, logic [3:0] code, logic [7:0] sched, logic [15:0] size);
    codeArr[ch]    = code;
    schedArr[ch]   = sched;
    sizeArr[ch]    = size;
    bus.ch_req[ch] = 1'b1;
  endtask

  // Sample just before the edge, let the edge happen, then advance sources and FIFO readiness.
  task automatic tick();
    #1;
    if (bus.out_valid && bus.out_ready) begin
      outQ.push_back({bus.out_sop, bus.out_last, bus.out_data});
      if (bus.out_last) lastAccCyc = cyc;
    end
    if (stallPrev && bus.out_valid)
      checkOutput("stall_stable", {30'd0, bus.out_sop, bus.out_last, bus.out_data}, {30'd0, heldWord});
    stallPrev = bus.out_valid && !bus.out_ready;
    heldWord  = {bus.out_sop, bus.out_last, bus.out_data};
    if (done) begin
      doneQ.push_back(int'(done_ch));
      doneCyc = cyc;
    end
    pendAcc = bus.ch_valid & bus.ch_ready;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.ch_grant[i]) bus.ch_req[i] = 1'b0;
    @(posedge clk_chip);
    #1;
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pendAcc[i]) srcSeq[i]++;
      dataArr[i] = mkWord(i, srcSeq[i]);
    end
    if (toggleMode) begin
      togCnt++;
      if (togCnt == 3) begin
        togCnt = 0;
        bus.out_ready = ~bus.out_ready;
      end
    end
  endtask

  task automatic resync();
    outQ.delete();
    doneQ.delete();
    for (int i = 0; i < NUM_CH; i++) expSeq[i] = srcSeq[i];
    stallPrev = 1'b0;
  endtask

  task automatic doReset();
    reset_n_chip = 1'b0;
    tick();
    tick();
    reset_n_chip = 1'b1;
    resync();
  endtask

  task automatic waitIdle(string tag, int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((busy || (bus.ch_req != '0)) && (k < budget));
    checkOutput(tag, (k < budget), 1);
  endtask

  task automatic checkPacket(int ch, logic [3:0] code, logic [7:0] sched, logic [15:0] size);
    logic [33:0] w;
    checkOutput("pkt_words", (outQ.size() >= int'(size) + 1), 1);
    if (outQ.size() < int'(size) + 1) return;
    w = outQ.pop_front();
    checkOutput("hdr_data", w[31:0], hdrWord(code, sched, ch, size));
    checkOutput("hdr_sop", w[33], 1);
    checkOutput("hdr_last", w[32], (size == 16'd0));
    for (int k = 0; k < int'(size); k++) begin
      w = outQ.pop_front();
      checkOutput("pay_data", w[31:0], mkWord(ch, expSeq[ch]));
      expSeq[ch]++;
      checkOutput("pay_sop", w[33], 0);
      checkOutput("pay_last", w[32], (k == int'(size) - 1));
    end
    checkOutput("done_seen", (doneQ.size() > 0), 1);
    if (doneQ.size() > 0) checkOutput("done_ch", doneQ.pop_front(), ch);
  endtask

  initial begin
    reset_n_chip  = 1'b0;
    flush         = 1'b0;
    bus.ch_req    = '0;
    bus.ch_valid  = '1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      codeArr[i]  = '0;
      schedArr[i] = '0;
      sizeArr[i]  = '0;
      srcSeq[i]   = 0;
      expSeq[i]   = 0;
      dataArr[i]  = mkWord(i, 0);
    end

    doReset();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_data", bus.out_data, 0);
    checkOutput("rst_grant", bus.ch_grant, 0);
    checkOutput("rst_ready", bus.ch_ready, 0);
    checkOutput("rst_done", done, 0);

    $display("[TB] single channel 1, size 3");
    applyStimulus(1, 4'hA, 8'h5C, 16'd3);
    waitIdle("t1_timeout", 100);
    checkPacket(1, 4'hA, 8'h5C, 16'd3);
    checkOutput("t1_extra", outQ.size(), 0);

    $display("[TB] four channels together, size 2");
    doReset();
    for (int i = 0; i < NUM_CH; i++) applyStimulus(i, 4'(i + 1), 8'(8'h10 + i), 16'd2);
    waitIdle("t2_timeout", 200);
    for (int i = 0; i < NUM_CH; i++) checkPacket(i, 4'(i + 1), 8'(8'h10 + i), 16'd2);
    applyStimulus(3, 4'h3, 8'h33, 16'd1);
    applyStimulus(0, 4'h0, 8'h00, 16'd1);
    waitIdle("t2_wrap_timeout", 100);
    checkPacket(0, 4'h0, 8'h00, 16'd1);
    checkPacket(3, 4'h3, 8'h33, 16'd1);

    $display("[TB] zero-length packet on channel 2");
    applyStimulus(2, 4'h7, 8'hE2, 16'd0);
    waitIdle("t3_timeout", 100);
    checkPacket(2, 4'h7, 8'hE2, 16'd0);
    checkOutput("t3_done_lat", doneCyc - lastAccCyc, 1);

    $display("[TB] size 8 with out_ready toggling");
    togCnt     = 0;
    toggleMode = 1'b1;
    applyStimulus(3, 4'h9, 8'h48, 16'd8);
    waitIdle("t4_timeout", 300);
    toggleMode    = 1'b0;
    bus.out_ready = 1'b1;
    checkPacket(3, 4'h9, 8'h48, 16'd8);

    $display("[TB] flush after 2 of 5 words");
    applyStimulus(1, 4'h5, 8'h55, 16'd5);
    startSeq = srcSeq[1];
    n = 0;
    while ((srcSeq[1] - startSeq < 2) && (n < 100)) begin
      tick();
      n++;
    end
    checkOutput("t5_reach", srcSeq[1] - startSeq, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_grant", bus.ch_grant, 0);
    checkOutput("t5_valid", bus.out_valid, 0);
    checkOutput("t5_no_done", doneQ.size(), 0);
    resync();
    applyStimulus(2, 4'h2, 8'h22, 16'd1);
    applyStimulus(1, 4'h1, 8'h11, 16'd2);
    waitIdle("t5_next_timeout", 100);
    checkPacket(1, 4'h1, 8'h11, 16'd2);
    checkPacket(2, 4'h2, 8'h22, 16'd1);

    $display("[TB] reset mid-packet");
    applyStimulus(3, 4'hC, 8'hCC, 16'd4);
    startSeq = srcSeq[3];
    n = 0;
    while ((srcSeq[3] - startSeq < 1) && (n < 100)) begin
      tick();
      n++;
    end
    checkOutput("t6_reach", srcSeq[3] - startSeq, 1);
    reset_n_chip = 1'b0;
    tick();
    checkOutput("t6_valid", bus.out_valid, 0);
    checkOutput("t6_data", bus.out_data, 0);
    checkOutput("t6_sop", bus.out_sop, 0);
    checkOutput("t6_last", bus.out_last, 0);
    checkOutput("t6_grant", bus.ch_grant, 0);
    checkOutput("t6_ready", bus.ch_ready, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_done", done, 0);
    checkOutput("t6_done_ch", done_ch, 0);
    reset_n_chip = 1'b1;
    resync();
    applyStimulus(3, 4'h6, 8'h66, 16'd1);
    applyStimulus(1, 4'h4, 8'h44, 16'd1);
    waitIdle("t6_next_timeout", 100);
    checkPacket(1, 4'h4, 8'h44, 16'd1);
    checkPacket(3, 4'h6, 8'h66, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
